// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver FSM state type
//
// Purpose: constants shared by uart_rx and the future uart_tx.
// Ports:   none (package).

package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_CLK_FREQ_HZ = 25_000_000;
    localparam int UART_BAUD_RATE   = 115_200;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser
//
// Purpose: brings an asynchronous single-bit signal into the clk domain.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset; both flops load RESET_VAL
//   i_d  - asynchronous input
//   o_q  - synchronised output, two cycles behind i_d

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - byte-oriented UART receiver with one-entry holding register
//
// Purpose: deserialises an 8N1 (or 8E1 with UART_RX_PARITY_EN defined) serial
//          line into bytes on a ready/valid interface, flagging framing,
//          parity and overrun errors.
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   rx_i         - asynchronous serial line, idles high
//   data_o       - received byte (stable while valid_o is high)
//   valid_o      - data_o holds an unconsumed byte
//   ready_i      - downstream accepts on valid_o && ready_i
//   frame_err_o  - 1-cycle pulse: stop bit sampled low
//   overrun_o    - 1-cycle pulse: completed byte dropped, register full
//   parity_err_o - 1-cycle pulse: even-parity mismatch (0 without parity)
// Build option: UART_RX_PARITY_EN adds an even-parity bit before the stop bit.

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = UART_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = UART_BAUD_RATE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o,
    output logic                      parity_err_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
            $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
        end
    endgenerate

    logic                      w_rx_s;
    logic                      w_stop_sample;
    logic                      w_par_flag;

    rx_state_t                 r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;

    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_i),
        .o_q (w_rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_flag;
    logic r_parity_err;

    assign w_par_flag   = r_par_flag;
    assign parity_err_o = r_parity_err;
`else
    assign w_par_flag   = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    // The counter is restarted on every state entry, so a sample always
    // falls on the cycle the counter reaches its end value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_flag <= 1'b0;
`endif
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        r_state   <= RX_START;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        r_par_flag <= 1'b0;
`endif
                    end
                end

                RX_START: begin
                    if (r_cnt == CNT_HALF_END) begin
                        r_cnt   <= '0;
                        // A line already back high mid-start-bit is a glitch.
                        r_state <= w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt      <= '0;
                        r_par_flag <= (w_rx_s != (^r_shift));
                        r_state    <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                RX_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge
                    // is seen as early as possible.
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= RX_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_stop_sample = (r_state == RX_STOP) && (r_cnt == CNT_BIT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_stop_sample) begin
                if (!w_rx_s) begin
                    r_frame_err <= 1'b1;
                end else if (w_par_flag) begin
`ifdef UART_RX_PARITY_EN
                    r_parity_err <= 1'b1;
`endif
                end else if (!r_valid || ready_i) begin
                    // Loading overrides the clear above when the old byte
                    // is consumed in this same cycle.
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int C      = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT    = 2 + 8 + 10 * C + 1;
`else
    localparam int LAT    = 2 + 8 + 9 * C + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_BYTE = 0, K_FERR = 1, K_OVR = 2, K_PERR = 3, K_NONE = 4} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_good;
        kind_t      kind;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;
    int last_rise = -1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input kind_t k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic observe(input kind_t k, input logic [7:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none (cycle %0d)", k, d, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", k, e.kind);
            if (e.kind == K_BYTE && k == K_BYTE) check("event_data", d, e.data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_good);
        rx_i = 1'b0;
        start_cyc = cyc;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (C) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx_i = (^d) ^ ~par_good;
        repeat (C) tick();
`endif
        rx_i = stop_bit;
        repeat (C) tick();
        rx_i = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_o"}, data_o, 8'h00);
        check({tag, "_valid_o"}, valid_o, 1'b0);
        check({tag, "_frame_err_o"}, frame_err_o, 1'b0);
        check({tag, "_overrun_o"}, overrun_o, 1'b0);
        check({tag, "_parity_err_o"}, parity_err_o, 1'b0);
    endtask

    // Monitor: outputs sampled on the falling edge, every event popped from the scoreboard.
    initial begin
        logic       prev_valid;
        logic       prev_cons;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_cons  = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid_o && !prev_valid) last_rise = cyc;
                if (prev_valid && !prev_cons && valid_o) check("hold_stable", data_o, prev_data);
                if (valid_o && ready_i) observe(K_BYTE, data_o);
                if (frame_err_o)  observe(K_FERR, 8'h00);
                if (overrun_o)    observe(K_OVR, 8'h00);
                if (parity_err_o) observe(K_PERR, 8'h00);
            end
            prev_valid = valid_o;
            prev_cons  = valid_o && ready_i;
            prev_data  = data_o;
        end
    end

    initial begin
        vecs.push_back('{8'h5A, 1'b0, 1'b1, K_FERR});
        vecs.push_back('{8'h81, 1'b1, 1'b1, K_BYTE});
        vecs.push_back('{8'h00, 1'b1, 1'b1, K_BYTE});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, K_BYTE});
        vecs.push_back('{8'h3C, 1'b1, 1'b1, K_BYTE});
        vecs.push_back('{8'h12, 1'b1, 1'b1, K_BYTE});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, K_PERR});
        vecs.push_back('{8'h07, 1'b1, 1'b1, K_BYTE});
        vecs.push_back('{8'hA5, 1'b0, 1'b0, K_FERR});
`endif

        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) tick();

        // First byte: exact latency and single-cycle valid with ready held high.
        push(K_BYTE, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        check("a5_latency", last_rise - start_cyc, LAT);
        check("a5_valid_one_cycle", valid_o, 1'b0);
        repeat (20) tick();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].kind != K_NONE) push(vecs[i].kind, vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_good);
            repeat (20) tick();
        end

        // Back-to-back frames into a full holding register.
        ready_i = 1'b0;
        push(K_OVR, 8'h00);
        push(K_OVR, 8'h00);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (5) tick();
        check("ovr_held_valid", valid_o, 1'b1);
        check("ovr_held_data", data_o, 8'h00);
        push(K_BYTE, 8'h00);
        ready_i = 1'b1;
        tick();
        check("ovr_valid_drop", valid_o, 1'b0);
        repeat (20) tick();

        // Short low glitch must not start a frame.
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        repeat (30) tick();
        check("glitch_no_valid", valid_o, 1'b0);
        push(K_BYTE, 8'h81);
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (20) tick();

        // Reset in the middle of the data bits of 8'hC3.
        rx_i = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 4; i++) begin
            rx_i = ((8'hC3 >> i) & 8'h01) != 0;
            repeat (C) tick();
        end
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (2) tick();
        check_all_zero("midreset");
        rst = 1'b0;
        repeat (40) tick();
        check("midreset_no_valid", valid_o, 1'b0);
        push(K_BYTE, 8'h12);
        send_frame(8'h12, 1'b1, 1'b1);
        repeat (20) tick();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented UART receiver that turns the serial line from the host into 8-bit bytes on a ready/valid interface. It sits directly upstream of the ALU command stage inside `top`. It consumes the board's serial input pin, which is already in the 25 MHz PLL domain once synchronised, and feeds the operand/opcode parser. It includes a single-entry output holding register, framing-error detection and overrun detection.

## Interface
- `CLK_FREQ_HZ`, default 25_000_000: system clock frequency.
- `BAUD_RATE`, default 115_200: line rate.
- Derived constant `CLKS_PER_BIT` = `CLK_FREQ_HZ / BAUD_RATE` (integer division). It must be ≥ 4; elaboration fails otherwise.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_i` input 1: asynchronous serial line; idles high.
- `data_o` output 8: received byte, LSB first on the wire.
- `valid_o` output 1: `data_o` holds an unconsumed byte.
- `ready_i` input 1: downstream accepts the byte when `valid_o && ready_i`.
- `frame_err_o` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_o` output 1: one-cycle pulse when a completed byte is dropped.
- `parity_err_o` output 1: one-cycle pulse on even-parity mismatch. Tied 0 when the parity feature is not compiled in.

## Operation
- `rx_i` passes through a 2-flop synchroniser; `rx_s` is the synchronised line. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Bit counter: `$clog2(CLKS_PER_BIT)` bits wide.
- IDLE: when `rx_s`=0, go to START and clear the bit counter.
- START: wait `H = CLKS_PER_BIT/2` cycles, then re-sample.
  - `rx_s`=0: go to DATA.
  - `rx_s`=1: treat as a glitch and return to IDLE with no output activity.
- DATA: sample every `CLKS_PER_BIT` cycles and shift into a shift register LSB-first. After 8 samples, go to PARITY (macro) or STOP.
- PARITY: sample one bit. A mismatch against even parity over the 8 data bits sets a sticky flag for this frame.
- STOP: sample at mid-bit, then return to IDLE in the next cycle. No wait for the end of the stop bit, so back-to-back frames resynchronise.
  - Stop bit 0: pulse `frame_err_o`; the byte is discarded.
  - Stop bit 1 with the parity flag set: pulse `parity_err_o`; the byte is discarded.
  - Otherwise: the byte completes.
- Holding register, on byte completion:
  - Load `data_o` and set `valid_o` if the register is empty (`!valid_o`) or is being consumed in the same cycle (`valid_o && ready_i`).
  - Otherwise the existing byte is kept, the new byte is dropped and `overrun_o` pulses.
- `valid_o` clears on `valid_o && ready_i` unless a new byte loads in the same cycle. `data_o` is stable while `valid_o` is high.
- Reset (including mid-frame): state IDLE, counters 0, shift register 0. The synchroniser flops reset to 1.

## Timing
- Reset values: `data_o`=8'h00, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0, `parity_err_o`=0.
- `rx_s` lags `rx_i` by 2 cycles. Let t0 be the first cycle with `rx_s`=0 in IDLE.
- Sample times:
  - Start bit re-check at t0+H.
  - Data bit i (0..7) at t0+H+(i+1)·`CLKS_PER_BIT`.
  - Parity bit at t0+H+9·`CLKS_PER_BIT`.
  - Stop bit at t0+H+9·`CLKS_PER_BIT`, or +10·`CLKS_PER_BIT` with parity.
- `valid_o` and any error/overrun pulse assert in the cycle after the stop sample. Each pulse is exactly 1 cycle.
- The earliest detection of the next frame's start is 1 cycle after the stop sample.
- Throughput is one byte per frame. `ready_i` may be held permanently high.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 1 start, 8 data, 1 even-parity bit, 1 stop.
  - PARITY state is present; `parity_err_o` is live.
- Not defined:
  - Frame is 8N1.
  - No PARITY state; `parity_err_o` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - The FSM state enum `rx_state_t`.
  - `UART_DATA_BITS`=8.
  - The shared default `CLK_FREQ_HZ`/`BAUD_RATE` constants, which the future `uart_tx` reuses.
- One sub-module, `sync_2ff`: generic 2-flop synchroniser with parameterised reset value, instantiated for `rx_i`.

## Test plan
Bench uses `CLK_FREQ_HZ`=1_600_000 and `BAUD_RATE`=100_000, giving `CLKS_PER_BIT`=16 and H=8.
- Send 8'hA5 in 8N1 with `ready_i`=1 → `valid_o` rises for one cycle with `data_o`=8'hA5 at t0+8+9·16+1; no error pulses.
- Send back-to-back 8'h00 and 8'hFF, then 8'h3C, with `ready_i`=0 → first byte 8'h00 is held and `overrun_o` pulses twice. Then raise `ready_i` → 8'h00 is consumed and `valid_o` drops.
- Send a frame with stop bit 0 and data 8'h5A → `frame_err_o` pulses once; `valid_o` stays 0.
- Drive `rx_i` low for 4 cycles, then high → no START acceptance, no outputs. A following 8'h81 frame is received correctly.
- Assert `rst` mid-way through the DATA bits of 8'hC3 → all outputs 0 and no `valid_o`. The next 8'h12 frame is received correctly.
- With `UART_RX_PARITY_EN`: send 8'h07 with parity bit 0 → `parity_err_o` pulses and no `valid_o`. Send it with parity bit 1 → `data_o`=8'h07 and `valid_o` asserts.
